alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//   Upstream controller for the siren beeper: converts an alarm trigger into a timed burst pattern
//   on the beeper's 'enable' input (ON/OFF bursts, fixed count), with acknowledge/abort.
//   Each burst drops enable low for >=1 cycle, so the beeper restarts its sweep per burst.
//   Sits between alarm sources (timers/keys) and the beeper in the alarm clock datapath.
// PARAMETERS
//   ON_CYCLES   25_000_000  clk cycles enable is high per burst (>=1, fits CNT_W)
//   OFF_CYCLES  25_000_000  clk cycles enable is low between bursts (>=1, fits CNT_W)
//   BURSTS      3           bursts per round (>=1, fits BURST_W)
//   CNT_W       25          width of the ON/OFF timer
//   BURST_W     4           width of the burst counter
// PORTS
//   clk          in   1        system clock; all logic on rising edge
//   rst_n        in   1        synchronous reset, active low
//   trigger      in   1        alarm request; start on a 0->1 edge only
//   ack          in   1        level; abort active alarm
//   enable       out  1        to beeper enable; registered
//   busy         out  1        registered; 1 while not IDLE
//   done         out  1        1-cycle pulse when a round completes normally
//   bursts_left  out  BURST_W  bursts remaining including the current one; 0 in IDLE
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): state=IDLE, enable=0, busy=0, done=0, bursts_left=0, timer=0,
//     trig_d=1. trig_d resets to 1, so trigger held high through reset starts nothing; start needs low then high.
//   - trig_rise = trigger & ~trig_d; trig_d <= trigger every edge.
//   - States: IDLE, ON, OFF. Outputs reflect the state after each edge: enable=(ON), busy=(!IDLE).
//   - IDLE: trig_rise & !ack -> ON, timer=ON_CYCLES-1, bursts_left=BURSTS. enable is high the edge
//     after the sampled rise, so latency is 1 cycle. If trig_rise & ack coincide, ack wins: stay IDLE.
//   - ON: timer!=0 -> decrement. timer==0:
//       bursts_left>1 -> OFF, timer=OFF_CYCLES-1, bursts_left-=1
//       bursts_left==1 -> IDLE, bursts_left=0, done=1 for this one cycle
//     enable is high exactly ON_CYCLES cycles per burst.
//   - OFF: timer!=0 -> decrement; timer==0 -> ON, timer=ON_CYCLES-1. enable is low exactly OFF_CYCLES cycles.
//   - ack=1 in ON or OFF: ack has priority over timer expiry. Next state is IDLE, enable=0, busy=0,
//     bursts_left=0, and done stays 0.
//   - trig_rise while busy: ignored. It is not queued and does not extend the pattern.
//   - done=0 in every cycle except the normal-completion cycle.
//   - Timer and burst arithmetic: unsigned; counters never underflow (load on 0, never decrement past 0).
// CONFIGURATION
//   ALARM_REPEAT_EN defined: at ON expiry with bursts_left==1, the round repeats:
//     -> OFF, timer=OFF_CYCLES-1, bursts_left=BURSTS. done pulses 1 cycle per completed round.
//     busy stays 1. Only ack or reset returns to IDLE.
//   ALARM_REPEAT_EN undefined: single round, then IDLE as described above.
// TESTING (ON_CYCLES=4, OFF_CYCLES=3, BURSTS=2)
//   1 Reset: rst_n=0 for 3 cycles with trigger=1, then release, trigger held 1
//     -> enable=0, busy=0, done=0, bursts_left=0 throughout; no alarm starts.
//   2 Trigger 1-cycle pulse -> enable: 4 cycles high, 3 low, 4 high, then 0. busy high for 11 cycles.
//     done=1 on the cycle enable last falls. bursts_left sequence 2,1,0.
//   3 Trigger, then ack=1 for 1 cycle during the 2nd ON -> enable=0, busy=0, bursts_left=0 next cycle;
//     done never pulses.
//   4 Second trigger pulse during OFF -> pattern identical to test 2 (11 busy cycles, one done).
//   5 In IDLE, trigger rise and ack=1 in the same cycle -> no start. A later clean rise starts normally.
//   6 rst_n=0 mid-ON -> all outputs at reset values the next cycle. A trigger rise after release starts normally.
//   7 ALARM_REPEAT_EN: trigger -> period-14 pattern (4 on/3 off/4 on/3 off) repeats, done every 14 cycles,
//     busy stays 1. ack -> IDLE next cycle.

Source files
------------

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//   Turns an alarm trigger into a timed burst pattern on the beeper's enable
//   input: BURSTS bursts of ON_CYCLES high separated by OFF_CYCLES low.
//   Enable drops low between bursts, so the beeper restarts its sweep on
//   every burst. An ack aborts an active alarm.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous reset, active low
//   trigger      alarm request; a round starts on a 0->1 edge only
//   ack          level; aborts an active alarm, and suppresses a start in IDLE
//   enable       registered beeper enable (high while in ON)
//   busy         registered, high while not IDLE
//   done         one-cycle pulse when a round completes normally
//   bursts_left  bursts remaining including the current one; 0 in IDLE
//
// Configuration macro
//   ALARM_REPEAT_EN : when defined, a completed round restarts after an OFF
//                     gap and repeats until ack or reset (done pulses once
//                     per round). When undefined, a single round is played.

module alarm_sequencer #(
   parameter int ON_CYCLES  = 25_000_000,
   parameter int OFF_CYCLES = 25_000_000,
   parameter int BURSTS     = 3,
   parameter int CNT_W      = 25,
   parameter int BURST_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               trigger,
   input  logic               ack,
   output logic               enable,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] bursts_left
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd1;
   localparam logic [1:0] ST_OFF  = 2'd2;

   localparam logic [CNT_W-1:0]   ON_LOAD    = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0]   OFF_LOAD   = CNT_W'(OFF_CYCLES - 1);
   localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(BURSTS);
   localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic [BURST_W-1:0] bursts_left_q, bursts_left_d;
   logic               enable_q, enable_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               trig_d_q, trig_d_d;
   logic               trig_rise;

   // trig_d_q resets to 1 so a trigger held high through reset cannot start
   // an alarm; a start needs trigger to be seen low, then high.
   assign trig_rise = trigger & ~trig_d_q;

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      bursts_left_d = bursts_left_q;
      done_d        = 1'b0;
      trig_d_d      = trigger;

      case (state_q)
         ST_IDLE: begin
            // ack wins over a coincident rise
            if (trig_rise && !ack) begin
               state_d       = ST_ON;
               timer_d       = ON_LOAD;
               bursts_left_d = BURST_LOAD;
            end
         end
         ST_ON: begin
            // ack takes priority over timer expiry
            if (ack) begin
               state_d       = ST_IDLE;
               timer_d       = '0;
               bursts_left_d = '0;
            end else if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else if (bursts_left_q > BURST_ONE) begin
               state_d       = ST_OFF;
               timer_d       = OFF_LOAD;
               bursts_left_d = bursts_left_q - 1'b1;
            end else begin
`ifdef ALARM_REPEAT_EN
               // last burst of a round: start the next round after a gap
               state_d       = ST_OFF;
               timer_d       = OFF_LOAD;
               bursts_left_d = BURST_LOAD;
               done_d        = 1'b1;
`else
               state_d       = ST_IDLE;
               timer_d       = '0;
               bursts_left_d = '0;
               done_d        = 1'b1;
`endif
            end
         end
         ST_OFF: begin
            if (ack) begin
               state_d       = ST_IDLE;
               timer_d       = '0;
               bursts_left_d = '0;
            end else if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else begin
               state_d = ST_ON;
               timer_d = ON_LOAD;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            timer_d       = '0;
            bursts_left_d = '0;
         end
      endcase

      // outputs are registered copies of the next-state decode
      enable_d = (state_d == ST_ON);
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         bursts_left_q <= '0;
         enable_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         trig_d_q      <= 1'b1;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         bursts_left_q <= bursts_left_d;
         enable_q      <= enable_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         trig_d_q      <= trig_d_d;
      end
   end

   assign enable      = enable_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign bursts_left = bursts_left_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer
//   Drives alarm_sequencer (ON=4, OFF=3, BURSTS=2) with directed scenarios
//   followed by randomized trigger/ack/reset traffic. Expected outputs come
//   from a timeline model: the cycle count since the round started decides
//   the phase, the burst number and the completion point.

module tb_alarm_sequencer;

   localparam int ON_C  = 4;
   localparam int OFF_C = 3;
   localparam int NB    = 2;
   localparam int P     = ON_C + OFF_C;   // one burst plus its gap
   localparam int R     = NB * P;         // one full round including final gap
   localparam int END_K = R - OFF_C;      // elapsed count at which the round ends

   logic       clk = 1'b0;
   logic       rst_n;
   logic       trigger;
   logic       ack;
   logic       enable;
   logic       busy;
   logic       done;
   logic [3:0] bursts_left;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_active;
   int m_k;
   bit m_trig_prev;
   bit m_done;

   always #5 clk = ~clk;

   alarm_sequencer #(
      .ON_CYCLES (ON_C),
      .OFF_CYCLES(OFF_C),
      .BURSTS    (NB),
      .CNT_W     (25),
      .BURST_W   (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .trigger    (trigger),
      .ack        (ack),
      .enable     (enable),
      .busy       (busy),
      .done       (done),
      .bursts_left(bursts_left)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs the DUT sees.
   function automatic void model_edge();
      bit rise;
      m_done = 1'b0;
      if (!rst_n) begin
         m_active    = 1'b0;
         m_k         = 0;
         m_trig_prev = 1'b1;
         return;
      end
      rise = trigger && !m_trig_prev;
      if (m_active) begin
         if (ack) begin
            m_active = 1'b0;
         end else begin
            m_k++;
`ifdef ALARM_REPEAT_EN
            if ((m_k % R) == END_K) m_done = 1'b1;
`else
            if (m_k == END_K) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
`endif
         end
      end else if (rise && !ack) begin
         m_active = 1'b1;
         m_k      = 0;
      end
      m_trig_prev = trigger;
   endfunction

   function automatic int exp_enable();
      return (m_active && ((m_k % P) < ON_C)) ? 1 : 0;
   endfunction

   function automatic int exp_bursts();
      int kk;
      if (!m_active) return 0;
`ifdef ALARM_REPEAT_EN
      kk = m_k % R;
      if (kk >= END_K) return NB;
`else
      kk = m_k;
`endif
      // the count drops when entering the gap that follows each burst
      return NB - (kk + OFF_C) / P;
   endfunction

   // One clock: apply inputs, let the edge happen, compare at the falling edge.
   task automatic step(input bit r, input bit t, input bit a);
      rst_n   = r;
      trigger = t;
      ack     = a;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("enable",      int'(enable),      exp_enable());
      check("busy",        int'(busy),        int'(m_active));
      check("done",        int'(done),        int'(m_done));
      check("bursts_left", int'(bursts_left), exp_bursts());
      $display("t=%0t rst_n=%0b trig=%0b ack=%0b -> en=%0b busy=%0b done=%0b bl=%0d",
               $time, r, t, a, enable, busy, done, bursts_left);
   endtask

   int done_count;

   initial begin
      rst_n       = 1'b0;
      trigger     = 1'b1;
      ack         = 1'b0;
      m_active    = 1'b0;
      m_k         = 0;
      m_trig_prev = 1'b1;
      m_done      = 1'b0;
      @(negedge clk);

      // reset with trigger held high, then release with trigger still high
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);

      // single clean pulse: full round, count done pulses
      step(1'b1, 1'b0, 1'b0);
      done_count = 0;
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 14; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (done) done_count++;
      end
`ifndef ALARM_REPEAT_EN
      check("done_count_round", done_count, 1);
`endif

      // ack during the second ON burst aborts
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);

      // second trigger pulse during OFF is ignored
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);

      // rise coincident with ack in IDLE does not start; later rise does
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      // reset mid-ON, then a fresh start
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 59) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
